// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C byte engine: command modes, FSM states and SDA levels.
package i2c_pkg;

  typedef enum logic [1:0] {
    MODE_ADDR  = 2'b00,
    MODE_WRITE = 2'b01,
    MODE_READ  = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_ACK   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic SDA_RELEASE = 1'b1;
  localparam logic SDA_LOW     = 1'b0;

  // Level the master puts on SDA during the ACK bit: it acknowledges a read unless it is the last one.
  function automatic logic ack_drive(input mode_e mode, input logic last);
    logic bit_v;
    if (mode == MODE_READ) begin
      bit_v = last ? SDA_RELEASE : SDA_LOW;
    end else begin
      bit_v = SDA_RELEASE;
    end
    return bit_v;
  endfunction

endpackage

// File: rtl/i2c_bit_counter.sv
// Loadable down-counter with zero flag; tracks how many bits of the frame remain.
module i2c_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load wins over decrement, and the counter never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != {CNT_W{1'b0}})) begin
      count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/i2c_byte_engine_chk.sv
// Debug checker: the SCL generator must never issue rise and fall strobes together.
module i2c_byte_engine_chk (
  input logic clk_i,
  input logic rst_i,
  input logic scl_fall_i,
  input logic scl_rise_i
);

  a_no_dual_strobe: assert property (@(posedge clk_i) disable iff (rst_i)
    !(scl_fall_i && scl_rise_i));

endmodule

// File: rtl/i2c_byte_engine.sv
// I2C byte engine: shifts one address/data frame MSB-first on SCL strobes, then runs the ACK bit.
module i2c_byte_engine
  import i2c_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 7,
  parameter int CNT_W     = 4
) (
  input  logic                 i2c_core_clk_i,
  input  logic                 reset_i,
  input  logic                 scl_fall_i,
  input  logic                 scl_rise_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_mode_i,
  input  logic                 cmd_last_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic                 rw_i,
  input  logic [DATA_SIZE-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_pop_o,
  input  logic                 i2c_sda_i,
  output logic                 i2c_sda_o,
  output logic [DATA_SIZE-1:0] rx_data_o,
  output logic                 rx_push_o,
  output logic                 ack_o,
  output logic                 done_o,
  output logic                 busy_o
);

  // Frames are left-aligned so the bit on the wire is always the register MSB.
  localparam int SH_W     = (DATA_SIZE > ADDR_SIZE + 1) ? DATA_SIZE : ADDR_SIZE + 1;
  localparam int ADDR_PAD = SH_W - ADDR_SIZE - 1;
  localparam int DATA_PAD = SH_W - DATA_SIZE;

  state_e               state_q;
  mode_e                mode_q;
  logic                 last_q;
  logic [SH_W-1:0]      shift_q;
  logic                 sda_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pop_q;
  logic                 push_q;
  logic                 ack_q;
  logic [DATA_SIZE-1:0] rx_q;

  logic                 rise_only_s;
  logic                 cnt_load_s;
  logic [CNT_W-1:0]     cnt_load_val_s;
  logic                 cnt_dec_s;
  logic [CNT_W-1:0]     cnt_count_s;
  logic                 cnt_zero_s;
  logic                 last_bit_s;

  // Counter control: load when LOAD commits, decrement on each sampling edge inside SHIFT.
  always_comb begin
    rise_only_s    = scl_rise_i && !scl_fall_i;
    cnt_load_s     = (state_q == ST_LOAD) && ((mode_q != MODE_WRITE) || tx_valid_i);
    cnt_dec_s      = (state_q == ST_SHIFT) && rise_only_s;
    cnt_load_val_s = CNT_W'(DATA_SIZE);
    if (mode_q == MODE_ADDR) begin
      cnt_load_val_s = CNT_W'(ADDR_SIZE + 1);
    end else begin
      cnt_load_val_s = CNT_W'(DATA_SIZE);
    end
    last_bit_s = cnt_zero_s || (cnt_count_s == {{(CNT_W-1){1'b0}}, 1'b1});
  end

  i2c_bit_counter #(
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk_i      (i2c_core_clk_i),
    .rst_i      (reset_i),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_load_val_s),
    .dec_i      (cnt_dec_s),
    .count_o    (cnt_count_s),
    .zero_o     (cnt_zero_s)
  );

  i2c_byte_engine_chk u_chk (
    .clk_i      (i2c_core_clk_i),
    .rst_i      (reset_i),
    .scl_fall_i (scl_fall_i),
    .scl_rise_i (scl_rise_i)
  );

  // Byte-engine FSM with all outputs registered; a fall strobe always wins over a simultaneous rise.
  always_ff @(posedge i2c_core_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ADDR;
      last_q  <= 1'b0;
      shift_q <= {SH_W{1'b0}};
      sda_q   <= SDA_RELEASE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pop_q   <= 1'b0;
      push_q  <= 1'b0;
      ack_q   <= 1'b1;
      rx_q    <= {DATA_SIZE{1'b0}};
    end else begin
      done_q <= 1'b0;
      pop_q  <= 1'b0;
      push_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i && ready_q && (mode_e'(cmd_mode_i) != MODE_RSVD)) begin
            mode_q  <= mode_e'(cmd_mode_i);
            last_q  <= cmd_last_i;
            state_q <= ST_LOAD;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          case (mode_q)
            MODE_ADDR: begin
              shift_q <= SH_W'({addr_i, rw_i}) << ADDR_PAD;
              state_q <= ST_SHIFT;
            end
            MODE_WRITE: begin
              if (tx_valid_i) begin
                shift_q <= SH_W'(tx_data_i) << DATA_PAD;
                pop_q   <= 1'b1;
                state_q <= ST_SHIFT;
              end else begin
                state_q <= ST_LOAD;
              end
            end
            MODE_READ: begin
              shift_q <= {SH_W{1'b0}};
              state_q <= ST_SHIFT;
            end
            default: begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          endcase
        end
        ST_SHIFT: begin
          if (scl_fall_i) begin
            sda_q <= (mode_q == MODE_READ) ? SDA_RELEASE : shift_q[SH_W-1];
          end else if (scl_rise_i) begin
            if (mode_q == MODE_READ) begin
              shift_q <= {shift_q[SH_W-2:0], i2c_sda_i};
            end else begin
              shift_q <= shift_q << 1;
            end
            if (last_bit_s) begin
              state_q <= ST_ACK;
            end else begin
              state_q <= ST_SHIFT;
            end
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_ACK: begin
          if (scl_fall_i) begin
            sda_q <= ack_drive(mode_q, last_q);
          end else if (scl_rise_i) begin
            if (mode_q == MODE_READ) begin
              rx_q   <= shift_q[DATA_SIZE-1:0];
              push_q <= 1'b1;
            end else begin
              ack_q <= i2c_sda_i;
            end
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_ACK;
          end
        end
        ST_DONE: begin
          if (scl_fall_i) begin
            sda_q   <= SDA_RELEASE;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sda_q   <= SDA_RELEASE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign tx_pop_o    = pop_q;
  assign rx_push_o   = push_q;
  assign ack_o       = ack_q;
  assign rx_data_o   = rx_q;
  assign i2c_sda_o   = sda_q;

endmodule

// File: tb/tb_i2c_byte_engine.sv
// Self-checking bench for i2c_byte_engine: directed and random frames against an I2C bit-level model.
module tb_i2c_byte_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       fall, rise, cmd_valid, cmd_ready, cmd_last, rw;
  logic [1:0] cmd_mode;
  logic [6:0] addr;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_pop, sda_o, sda_i, rx_push, ack, done, busy, slv;

  logic        w_fall, w_rise, w_cmd_valid, w_cmd_ready, w_cmd_last, w_rw;
  logic [1:0]  w_cmd_mode;
  logic [6:0]  w_addr;
  logic [15:0] w_tx_data, w_rx_data;
  logic        w_tx_valid, w_tx_pop, w_sda_o, w_sda_i, w_rx_push, w_ack, w_done, w_busy, w_slv;

  // Open-drain bus: either side pulling low wins.
  assign sda_i   = sda_o & slv;
  assign w_sda_i = w_sda_o & w_slv;

  int total = 0;
  int bad   = 0;
  int pop_cnt = 0, push_cnt = 0, done_cnt = 0;
  int w_push_cnt = 0, w_done_cnt = 0;

  i2c_byte_engine dut (
    .i2c_core_clk_i(clk), .reset_i(rst), .scl_fall_i(fall), .scl_rise_i(rise),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_mode_i(cmd_mode),
    .cmd_last_i(cmd_last), .addr_i(addr), .rw_i(rw), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid), .tx_pop_o(tx_pop), .i2c_sda_i(sda_i), .i2c_sda_o(sda_o),
    .rx_data_o(rx_data), .rx_push_o(rx_push), .ack_o(ack), .done_o(done), .busy_o(busy)
  );

  i2c_byte_engine #(.DATA_SIZE(16), .ADDR_SIZE(7), .CNT_W(5)) dut_w (
    .i2c_core_clk_i(clk), .reset_i(rst), .scl_fall_i(w_fall), .scl_rise_i(w_rise),
    .cmd_valid_i(w_cmd_valid), .cmd_ready_o(w_cmd_ready), .cmd_mode_i(w_cmd_mode),
    .cmd_last_i(w_cmd_last), .addr_i(w_addr), .rw_i(w_rw), .tx_data_i(w_tx_data),
    .tx_valid_i(w_tx_valid), .tx_pop_o(w_tx_pop), .i2c_sda_i(w_sda_i), .i2c_sda_o(w_sda_o),
    .rx_data_o(w_rx_data), .rx_push_o(w_rx_push), .ack_o(w_ack), .done_o(w_done), .busy_o(w_busy)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_pop)    pop_cnt++;
    if (rx_push)   push_cnt++;
    if (done)      done_cnt++;
    if (w_rx_push) w_push_cnt++;
    if (w_done)    w_done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(1, 3)) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SCL period: fall strobe, slave places its bit, rise strobe; returns what the master drove.
  task automatic bit_cycle(input logic slave_bit, output logic seen);
    fall = 1'b1; tick(); fall = 1'b0;
    gap();
    seen = sda_o;
    slv  = slave_bit;
    gap();
    rise = 1'b1; tick(); rise = 1'b0;
    chk("sda_stable_on_rise", sda_o, seen);
    gap();
    slv = 1'b1;
  endtask

  // Full command against the reference I2C model: frame bits MSB first, ACK bit, closing fall.
  task automatic xfer(input logic [1:0] mode, input logic last, input logic [6:0] a, input logic r,
                      input logic [7:0] wd, input logic [7:0] sd, input logic sack, input int stall);
    logic [7:0] frame;
    logic [7:0] prev_rx;
    logic       prev_ack, seen, is_read, exp_bit;
    is_read  = (mode == 2'b10);
    frame    = (mode == 2'b00) ? {a, r} : wd;
    prev_rx  = rx_data;
    prev_ack = ack;
    addr = a; rw = r; tx_data = wd; tx_valid = (stall == 0);
    pop_cnt = 0; push_cnt = 0; done_cnt = 0;
    chk("ready_idle", cmd_ready, 1'b1);
    cmd_mode = mode; cmd_last = last; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    chk("not_ready_when_busy", cmd_ready, 1'b0);
    if (stall > 0) begin
      for (int k = 0; k < stall; k++) begin
        fall = (k % 2 == 0);
        rise = (k % 2 == 1);
        tick();
      end
      fall = 1'b0; rise = 1'b0;
      tick();
      chk("no_pop_while_empty", pop_cnt, 0);
      chk("sda_held_while_empty", sda_o, 1'b1);
      chk("busy_while_empty", busy, 1'b1);
      tx_valid = 1'b1;
    end
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      bit_cycle(is_read ? sd[7-i] : 1'b1, seen);
      exp_bit = is_read ? 1'b1 : frame[7-i];
      chk("frame_bit", seen, exp_bit);
    end
    chk("no_push_before_ack", push_cnt, 0);
    bit_cycle(is_read ? 1'b1 : sack, seen);
    chk("ack_bit_drive", seen, is_read ? last : 1'b1);
    chk("push_count", push_cnt, is_read ? 1 : 0);
    chk("rx_data", rx_data, is_read ? sd : prev_rx);
    chk("ack_out", ack, is_read ? prev_ack : sack);
    chk("busy_before_close", busy, 1'b1);
    fall = 1'b1; tick(); fall = 1'b0;
    chk("done_high", done, 1'b1);
    chk("sda_released", sda_o, 1'b1);
    tick();
    chk("done_one_cycle", done, 1'b0);
    chk("ready_after_done", cmd_ready, 1'b1);
    chk("idle_after_done", busy, 1'b0);
    tick();
    chk("done_count", done_cnt, 1);
    chk("pop_count", pop_cnt, (mode == 2'b01) ? 1 : 0);
  endtask

  initial begin
    logic [15:0] wd16;
    logic        seen;
    logic [1:0]  rm;
    rst = 1'b1; fall = 1'b0; rise = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_last = 1'b0;
    addr = 7'h00; rw = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; slv = 1'b1;
    w_fall = 1'b0; w_rise = 1'b0; w_cmd_valid = 1'b0; w_cmd_mode = 2'b10; w_cmd_last = 1'b0;
    w_addr = 7'h00; w_rw = 1'b0; w_tx_data = 16'h0000; w_tx_valid = 1'b0; w_slv = 1'b1;
    tick(); tick();
    chk("rst_sda", sda_o, 1'b1);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pop", tx_pop, 1'b0);
    chk("rst_push", rx_push, 1'b0);
    chk("rst_ack", ack, 1'b1);
    chk("rst_rx", rx_data, 8'h00);
    rst = 1'b0;
    tick();

    xfer(2'b00, 1'b0, 7'h50, 1'b0, 8'h00, 8'h00, 1'b0, 0);
    xfer(2'b01, 1'b0, 7'h00, 1'b0, 8'hA5, 8'h00, 1'b1, 0);
    xfer(2'b10, 1'b0, 7'h00, 1'b0, 8'h00, 8'h3C, 1'b0, 0);
    xfer(2'b10, 1'b1, 7'h00, 1'b0, 8'h00, 8'h3C, 1'b0, 0);
    xfer(2'b01, 1'b0, 7'h00, 1'b0, 8'($urandom), 8'h00, 1'b0, 20);

    // Reserved mode is dropped without leaving IDLE.
    cmd_mode = 2'b11; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("rsvd_ready", cmd_ready, 1'b1);
    chk("rsvd_busy", busy, 1'b0);
    tick();
    chk("rsvd_still_idle", busy, 1'b0);

    // Reset in the middle of a WRITE.
    tx_data = 8'hA5; tx_valid = 1'b1; cmd_mode = 2'b01; cmd_last = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, seen);
    chk("sda_low_before_reset", sda_o, 1'b0);
    push_cnt = 0; done_cnt = 0;
    #2 rst = 1'b1;
    #1;
    chk("reset_sda_now", sda_o, 1'b1);
    chk("reset_busy_now", busy, 1'b0);
    chk("reset_ready_now", cmd_ready, 1'b1);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_no_push", push_cnt, 0);
    chk("reset_no_done", done_cnt, 0);
    xfer(2'b00, 1'b0, 7'($urandom), 1'b1, 8'h00, 8'h00, 1'b0, 0);

    // Random frames against the model.
    for (int n = 0; n < 8; n++) begin
      rm = 2'($urandom_range(0, 2));
      xfer(rm, 1'($urandom), 7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom), 0);
    end

    // 16-bit instance: full-width READ.
    for (int t = 0; t < 2; t++) begin
      wd16 = (t == 0) ? 16'hBEEF : 16'($urandom);
      w_push_cnt = 0; w_done_cnt = 0;
      w_cmd_mode = 2'b10; w_cmd_last = (t == 1); w_cmd_valid = 1'b1;
      tick();
      w_cmd_valid = 1'b0;
      tick(); tick();
      for (int i = 0; i < 16; i++) begin
        w_fall = 1'b1; tick(); w_fall = 1'b0; tick();
        chk("w_master_released", w_sda_o, 1'b1);
        w_slv = wd16[15-i];
        tick();
        w_rise = 1'b1; tick(); w_rise = 1'b0; tick();
        w_slv = 1'b1;
      end
      chk("w_no_push_before_ack", w_push_cnt, 0);
      w_fall = 1'b1; tick(); w_fall = 1'b0; tick();
      chk("w_ack_drive", w_sda_o, (t == 1) ? 1'b1 : 1'b0);
      w_rise = 1'b1; tick(); w_rise = 1'b0; tick();
      chk("w_rx_data", w_rx_data, wd16);
      chk("w_push_count", w_push_cnt, 1);
      w_fall = 1'b1; tick(); w_fall = 1'b0; tick();
      chk("w_done_count", w_done_cnt, 1);
      chk("w_idle", w_busy, 1'b0);
      chk("w_sda_released", w_sda_o, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_byte_engine.md
Name: i2c_byte_engine

Overview:
- Parametrised bit-level shift engine for the I2C master core: serialises one address or data word onto SDA, or deserialises one from SDA, then runs the ACK/NACK bit.
- Sits between the master FSM (command/strobe side) and the TX/RX FIFOs; the SCL generator supplies drive and sample strobes.
- Generalises the combinational data path with the following additions:
  - internal bit counter;
  - strobe-aligned MSB-first shifting;
  - ACK capture and generation;
  - a FIFO handshake.

Parameters:
- DATA_SIZE, 8, data word width in bits; must be at least 2.
- ADDR_SIZE, 7, slave address width. The address frame is ADDR_SIZE+1 bits (address followed by R/W).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > max(DATA_SIZE, ADDR_SIZE+1).

Ports:
- i2c_core_clk_i  in  1  core clock
- reset_i  in  1  asynchronous active-high reset
- scl_fall_i  in  1  one-cycle strobe: SCL falling edge; SDA may change now
- scl_rise_i  in  1  one-cycle strobe: SCL rising edge; sample SDA now
- cmd_valid_i  in  1  command request from master FSM
- cmd_ready_o  out  1  engine idle and able to accept a command
- cmd_mode_i  in  2  00 = ADDR, 01 = WRITE, 10 = READ, 11 = reserved (ignored)
- cmd_last_i  in  1  READ only: when 1, answer NACK after the byte
- addr_i  in  ADDR_SIZE  slave address
- rw_i  in  1  R/W bit appended to the address frame
- tx_data_i  in  DATA_SIZE  TX FIFO head
- tx_valid_i  in  1  TX FIFO not empty
- tx_pop_o  out  1  one-cycle pop of TX FIFO
- i2c_sda_i  in  1  synchronised SDA input
- i2c_sda_o  out  1  SDA drive: 0 pulls low, 1 releases
- rx_data_o  out  DATA_SIZE  received word
- rx_push_o  out  1  one-cycle push to RX FIFO
- ack_o  out  1  sampled ACK bit after ADDR/WRITE (0 = ACK)
- done_o  out  1  one-cycle pulse at end of ACK bit
- busy_o  out  1  command in progress

Behaviour:
- Reset (async, immediate), all outputs and registers at their reset values:
  - i2c_sda_o = 1, cmd_ready_o = 1;
  - busy_o, done_o, tx_pop_o, rx_push_o = 0;
  - ack_o = 1, rx_data_o = 0;
  - FSM in IDLE, counter cleared.
- Reset mid-transfer releases SDA in the same instant. No partial push or pop occurs.
- FSM states: IDLE, LOAD, SHIFT, ACK, DONE.
- IDLE:
  - Accept when cmd_valid_i && cmd_ready_o (cmd_ready_o = 1 only in IDLE).
  - Latch mode and last; go to LOAD.
  - Mode 11 is dropped: stay in IDLE, no other output changes.
- LOAD:
  - ADDR: shift register = {addr_i, rw_i}, count = ADDR_SIZE+1.
  - WRITE: wait while tx_valid_i = 0 (SDA holds its current value). When valid, load tx_data_i, assert tx_pop_o for exactly that cycle, count = DATA_SIZE.
  - READ: count = DATA_SIZE, shift register cleared.
  - Next state SHIFT.
- SHIFT:
  - On scl_fall_i: drive i2c_sda_o = shift MSB (ADDR/WRITE), or 1 (READ).
  - On scl_rise_i:
    - READ: shift i2c_sda_i into the LSB.
    - All modes: decrement count.
    - ADDR/WRITE: shift left after sampling edge.
  - When count reaches 0 on a rise, go to ACK.
- ACK:
  - On scl_fall_i: drive 1 (ADDR/WRITE); for READ, drive 0 if last = 0, else 1 (NACK).
  - On scl_rise_i:
    - ADDR/WRITE: ack_o <= i2c_sda_i.
    - READ: rx_data_o <= shift register, rx_push_o pulses for one cycle.
    - Go to DONE.
- DONE:
  - Wait for next scl_fall_i, then release SDA (1).
  - Pulse done_o for one cycle and return to IDLE (cmd_ready_o = 1 next cycle).
- Latency, counted in SCL periods: the word occupies N rise strobes (N = frame width), plus 1 for ACK, plus the closing fall.
- Data bits change only on scl_fall_i, never on scl_rise_i.
- If scl_fall_i and scl_rise_i are both asserted in one cycle: treat as protocol error. Rise is ignored and fall is processed (debug assertion fires).
- Strobes arriving in IDLE or LOAD are ignored.
- ack_o holds until the next ADDR/WRITE ACK sample. rx_data_o holds until the next push.
- busy_o = (state != IDLE).

Decomposition:
- Shared package i2c_pkg:
  - mode encodings MODE_ADDR/WRITE/READ;
  - FSM state encodings;
  - SDA_RELEASE = 1, SDA_LOW = 0.
- One natural sub-module: i2c_bit_counter, a loadable down-counter with a zero flag, parametrised by CNT_W.

Test Plan:
1. ADDR, addr_i=7'h50, rw_i=0 → SDA on successive falls 1,0,1,0,0,0,0,0. Slave drives 0 at ACK rise → ack_o=0, done_o pulses once.
2. WRITE, tx_data_i=8'hA5, tx_valid_i=1 → tx_pop_o exactly one cycle. SDA bits 1,0,1,0,0,1,0,1. Slave NACK (1) → ack_o=1.
3. READ, last=0, slave drives 8'h3C → rx_data_o=8'h3C, rx_push_o one cycle, SDA=0 during ACK bit. Repeat with last=1 → SDA=1 during ACK.
4. WRITE with tx_valid_i=0 for 20 cycles, then 1 → no strobes consumed and no pop until valid. Byte then completes normally.
5. Assert reset_i after 4 bits of a WRITE → SDA=1 immediately, busy_o=0, no rx_push_o/done_o. Next ADDR command works.
6. DATA_SIZE=16, CNT_W=5, READ of 16'hBEEF → 16 samples, then ACK, rx_data_o=16'hBEEF.
